// File: rtl/line_encoder.sv
// rtl/line_encoder.sv - serializes light-grid instructions into ASCII puzzle text lines
module line_encoder #(
    parameter int OUTBOUND_DATA_WIDTH = 8,
    parameter int POSITION_WIDTH      = 12,
    parameter int INSTRUCTION_WIDTH   = 52
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           instr_valid,
    output logic                           instr_ready,
    input  logic [INSTRUCTION_WIDTH-1:0]   instr_data,
    output logic                           outbound_valid,
    input  logic                           outbound_ready,
    output logic [OUTBOUND_DATA_WIDTH-1:0] outbound_data,
    output logic                           done
);

    localparam int PW = POSITION_WIDTH;
    localparam int IW = INSTRUCTION_WIDTH;

    typedef enum logic [3:0] {
        IDLE, PREP, OPCODE, START_ROW, COMMA0, START_COL, THROUGH,
        END_ROW, COMMA1, END_COL, NEWLINE, EOF0, EOF1, DONE
    } state_t;

    localparam logic [71:0] TXT_OFF  = "turn off ";
    localparam logic [71:0] TXT_ON   = {8'h00, "turn on "};
    localparam logic [71:0] TXT_TOG  = {16'h0000, "toggle "};
    localparam logic [71:0] TXT_THRU = " through ";

    state_t         state, state_nxt;
    logic           last_q, marker_q;
    logic [1:0]     op_q;
    logic [PW-1:0]  coord_q [4];
    logic [15:0]    bcd_q [4];
    logic [3:0]     idx, last_idx;
    logic [7:0]     ch;
    logic           accept, xfer;

    // Text constants are LSB-aligned, so character i of a len-char string sits at byte len-1-i.
    function automatic logic [7:0] char_at(input logic [71:0] s, input logic [3:0] len_m1,
                                           input logic [3:0] i);
        logic [3:0] k;
        k = len_m1 - i;
        return s[{k, 3'b000} +: 8];
    endfunction

    function automatic logic [15:0] to_bcd(input logic [PW-1:0] v);
        int unsigned x;
        x = 32'(v);
        return {4'(x / 1000 % 10), 4'(x / 100 % 10), 4'(x / 10 % 10), 4'(x % 10)};
    endfunction

    function automatic logic [1:0] ndig_m1(input logic [15:0] b);
        if (b[15:12] != 4'd0)     return 2'd3;
        else if (b[11:8] != 4'd0) return 2'd2;
        else if (b[7:4] != 4'd0)  return 2'd1;
        else                      return 2'd0;
    endfunction

    function automatic logic [7:0] digit_at(input logic [15:0] b, input logic [1:0] i);
        logic [1:0] k;
        k = ndig_m1(b) - i;
        return {4'h3, b[{k, 2'b00} +: 4]};
    endfunction

    assign accept = instr_valid && instr_ready;
    assign xfer   = outbound_valid && outbound_ready;
    assign done   = (state == DONE);
    assign outbound_data = OUTBOUND_DATA_WIDTH'(ch);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            instr_ready <= 1'b0;
            idx         <= 4'd0;
            last_q      <= 1'b0;
            marker_q    <= 1'b0;
            op_q        <= 2'b00;
            for (int i = 0; i < 4; i++) begin
                coord_q[i] <= '0;
                bcd_q[i]   <= '0;
            end
        end else begin
            state       <= state_nxt;
            instr_ready <= (state_nxt == IDLE);
            if (state_nxt != state)
                idx <= 4'd0;
            else if (xfer)
                idx <= idx + 4'd1;
            if (accept) begin
                last_q   <= instr_data[IW-1];
                marker_q <= instr_data[IW-2];
                op_q     <= instr_data[IW-3 -: 2];
                for (int i = 0; i < 4; i++)
                    coord_q[i] <= instr_data[IW-5-i*PW -: PW];
            end
            if (state == PREP) begin
                for (int i = 0; i < 4; i++)
                    bcd_q[i] <= to_bcd(coord_q[i]);
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        ch             = 8'h00;
        last_idx       = 4'd0;
        outbound_valid = 1'b1;
        case (state)
            IDLE: begin
                outbound_valid = 1'b0;
                if (accept) state_nxt = PREP;
            end
            PREP: begin
                outbound_valid = 1'b0;
                state_nxt = marker_q ? OPCODE : (last_q ? EOF0 : IDLE);
            end
            OPCODE: begin
                case (op_q)
                    2'b00:   begin ch = char_at(TXT_OFF, 4'd8, idx); last_idx = 4'd8; end
                    2'b11:   begin ch = char_at(TXT_ON,  4'd7, idx); last_idx = 4'd7; end
                    default: begin ch = char_at(TXT_TOG, 4'd6, idx); last_idx = 4'd6; end
                endcase
            end
            START_ROW: begin ch = digit_at(bcd_q[0], idx[1:0]); last_idx = {2'b00, ndig_m1(bcd_q[0])}; end
            START_COL: begin ch = digit_at(bcd_q[1], idx[1:0]); last_idx = {2'b00, ndig_m1(bcd_q[1])}; end
            END_ROW:   begin ch = digit_at(bcd_q[2], idx[1:0]); last_idx = {2'b00, ndig_m1(bcd_q[2])}; end
            END_COL:   begin ch = digit_at(bcd_q[3], idx[1:0]); last_idx = {2'b00, ndig_m1(bcd_q[3])}; end
            COMMA0, COMMA1: ch = 8'h2C;
            THROUGH:   begin ch = char_at(TXT_THRU, 4'd8, idx); last_idx = 4'd8; end
            NEWLINE:   ch = 8'h0A;
            EOF0, EOF1: ch = 8'h00;
            default:   outbound_valid = 1'b0;
        endcase
        if (xfer && idx == last_idx) begin
            case (state)
                OPCODE:    state_nxt = START_ROW;
                START_ROW: state_nxt = COMMA0;
                COMMA0:    state_nxt = START_COL;
                START_COL: state_nxt = THROUGH;
                THROUGH:   state_nxt = END_ROW;
                END_ROW:   state_nxt = COMMA1;
                COMMA1:    state_nxt = END_COL;
                END_COL:   state_nxt = NEWLINE;
                NEWLINE:   state_nxt = last_q ? EOF0 : IDLE;
                EOF0:      state_nxt = EOF1;
                EOF1:      state_nxt = DONE;
                default:   state_nxt = state;
            endcase
        end
    end

endmodule

// File: tb/tb_line_encoder.sv
// tb/tb_line_encoder.sv - directed self-checking bench for line_encoder
module tb_line_encoder;

    logic        clk, rst;
    logic        instr_valid, instr_ready;
    logic [51:0] instr_data;
    logic        outbound_valid, outbound_ready;
    logic [7:0]  outbound_data;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int ready_cyc = 0;
    bit stall_mode = 0;
    bit prev_stall = 0;
    bit prev_ready = 0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] q_data[$];
    int         q_cyc[$];

    line_encoder #(
        .OUTBOUND_DATA_WIDTH(8),
        .POSITION_WIDTH(12),
        .INSTRUCTION_WIDTH(52)
    ) dut (
        .clk(clk),
        .reset(rst),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_data(instr_data),
        .outbound_valid(outbound_valid),
        .outbound_ready(outbound_ready),
        .outbound_data(outbound_data),
        .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        outbound_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            outbound_ready = stall_mode ? ~outbound_ready : 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
            prev_ready <= 1'b0;
        end else begin
            if (prev_stall)
                check("hold", {55'd0, outbound_valid, outbound_data}, {55'd0, 1'b1, prev_data});
            if (outbound_valid && outbound_ready) begin
                q_data.push_back(outbound_data);
                q_cyc.push_back(cyc);
            end
            if (instr_ready && !prev_ready) ready_cyc <= cyc;
            prev_stall <= outbound_valid && !outbound_ready;
            prev_data  <= outbound_data;
            prev_ready <= instr_ready;
        end
    end

    function automatic logic [51:0] mk(input bit last, input bit marker, input logic [1:0] op,
                                       input int a, input int b, input int c, input int d);
        return {last, marker, op, 12'(a), 12'(b), 12'(c), 12'(d)};
    endfunction

    task automatic clear_q();
        q_data.delete();
        q_cyc.delete();
    endtask

    task automatic send(input logic [51:0] d);
        bit ok = 0;
        instr_data  = d;
        instr_valid = 1'b1;
        for (int g = 0; g < 100 && !ok; g++) begin
            @(negedge clk);
            if (instr_ready) begin
                ok = 1;
                acc_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr_data  = 52'hF_FFFF_FFFF_FFFF;
        check("accept", 64'(ok), 64'd1);
    endtask

    task automatic check_line(input string tag, input string exp, input int nul);
        int total = exp.len() + nul;
        for (int g = 0; g < 500 && q_data.size() < total; g++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_len"}, 64'(q_data.size()), 64'(total));
        for (int i = 0; i < total && i < q_data.size(); i++) begin
            logic [7:0] e;
            e = (i < exp.len()) ? exp[i] : 8'h00;
            check($sformatf("%s[%0d]", tag, i), 64'(q_data[i]), 64'(e));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(instr_ready), 64'd0);
        check("rst_valid", 64'(outbound_valid), 64'd0);
        check("rst_data",  64'(outbound_data), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        rst = 1'b0;
        clear_q();

        send(mk(0, 1, 2'b01, 0, 0, 999, 0));
        check_line("t1", "toggle 0,0 through 999,0\n", 0);
        check("t1_first_cyc", 64'(q_cyc[0]), 64'(acc_cyc + 2));
        check("t1_last_cyc",  64'(q_cyc[24]), 64'(acc_cyc + 26));
        check("t1_ready_cyc", 64'(ready_cyc), 64'(acc_cyc + 27));
        clear_q();

        send(mk(0, 1, 2'b11, 4095, 10, 7, 100));
        check_line("on", "turn on 4095,10 through 7,100\n", 0);
        clear_q();
        send(mk(0, 1, 2'b10, 1, 2, 3, 4));
        check_line("op10", "toggle 1,2 through 3,4\n", 0);
        clear_q();

        stall_mode = 1;
        send(mk(0, 1, 2'b00, 12, 305, 0, 4095));
        check_line("stall", "turn off 12,305 through 0,4095\n", 0);
        stall_mode = 0;
        clear_q();

        send(mk(0, 1, 2'b01, 10, 20, 30, 40));
        for (int g = 0; g < 100 && q_data.size() < 5; g++) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(outbound_valid), 64'd0);
        check("midrst_data",  64'(outbound_data), 64'd0);
        check("midrst_ready", 64'(instr_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_q();
        send(mk(0, 1, 2'b01, 10, 20, 30, 40));
        check_line("after_rst", "toggle 10,20 through 30,40\n", 0);
        clear_q();

        send(mk(0, 0, 2'b11, 5, 6, 7, 8));
        repeat (10) @(posedge clk);
        #1;
        check("m0_nobytes", 64'(q_data.size()), 64'd0);
        check("m0_ready",   64'(instr_ready), 64'd1);

        send(mk(1, 1, 2'b00, 1, 2, 3, 4));
        check_line("eof", "turn off 1,2 through 3,4\n", 2);
        check("eof_done",  64'(done), 64'd1);
        check("eof_ready", 64'(instr_ready), 64'd0);
        clear_q();
        instr_valid = 1'b1;
        instr_data  = mk(0, 1, 2'b01, 1, 1, 1, 1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("done_noaccept", 64'(instr_ready), 64'd0);
        end
        instr_valid = 1'b0;
        check("done_nobytes", 64'(q_data.size()), 64'd0);
        check("done_sticky",  64'(done), 64'd1);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_q();
        send(mk(1, 0, 2'b11, 9, 9, 9, 9));
        check_line("m0_eof", "", 2);
        check("m0_eof_done", 64'(done), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
